// File: rtl/bus_target_pkg.sv
// Shared definitions for the burst-bus target RAM: bus widths and FSM state encoding.
package bus_target_pkg;

  localparam int BUS_W  = 32;
  localparam int BEAT_W = 8;
  localparam int LANES  = 4;
  localparam int WAIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_BURST = 3'd2,
    S_RD_END   = 3'd3,
    S_WR       = 3'd4,
    S_ERR      = 3'd5
  } state_t;

endpackage

// File: rtl/bus_target_sram.sv
// Single-port synchronous RAM, 32-bit words with per-byte-lane write enables.
module bus_target_sram
  import bus_target_pkg::*;
#(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [LANES-1:0]     i_be,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [BUS_W-1:0]     i_wdata,
  output logic [BUS_W-1:0]     o_rdata
);

  logic [BUS_W-1:0] r_mem [2**ADDR_BITS];
  logic [BUS_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_burst_target_ram.sv
// Burst-bus responder: decodes a fixed window and serves single/burst reads and writes
// from a local RAM. Every output idles at 0 so it can be ORed onto the shared bus.
module bus_burst_target_ram
  import bus_target_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
  parameter int          ADDR_BITS   = 9,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              beginTransactionIn,
  input  logic [BUS_W-1:0]  addressDataIn,
  input  logic              readNotWriteIn,
  input  logic [BEAT_W-1:0] burstSizeIn,
  input  logic [LANES-1:0]  byteEnablesIn,
  input  logic              dataValidIn,
  input  logic              endTransactionIn,
  output logic [BUS_W-1:0]  addressDataOut,
  output logic              dataValidOut,
  output logic              endTransactionOut,
  output logic              busyOut,
  output logic              busErrorOut,
  output state_t            debugStateOut
);

  localparam int DEPTH = 2**ADDR_BITS;

  // Handshake: a read beat is valid in every cycle dataValidOut=1; a write beat is
  // taken in any WR cycle with dataValidIn=1 and busyOut=0 while beats remain.
  state_t                r_state;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [BEAT_W-1:0]     r_beat;
  logic [WAIT_W-1:0]     r_wait;
  logic [LANES-1:0]      r_be;
  logic                  r_wr_done;
  logic                  r_dv;
  logic                  r_end;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_hit;
  logic [ADDR_BITS-1:0]  w_idx;
  logic [31:0]           w_span;
  logic                  w_overrun;
  logic                  w_wr_accept;
  logic                  w_rd_issue;
  logic [BUS_W-1:0]      w_rdata;
  logic                  w_unused;

  assign w_hit     = addressDataIn[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
  assign w_idx     = addressDataIn[ADDR_BITS+1:2];
  assign w_span    = 32'(w_idx) + 32'(burstSizeIn);
  assign w_overrun = w_span >= 32'(DEPTH);
  assign w_unused  = ^addressDataIn[1:0];

  assign w_wr_accept = (r_state == S_WR) && dataValidIn && !r_busy && !r_wr_done;
  assign w_rd_issue  = !endTransactionIn &&
                       (((r_state == S_RD_WAIT) && (r_wait == '0)) ||
                        ((r_state == S_RD_BURST) && (r_beat != '0)));

  bus_target_sram #(.ADDR_BITS(ADDR_BITS)) u_sram (
    .clk     (clock),
    .i_we    (w_wr_accept),
    .i_be    (r_be),
    .i_re    (w_rd_issue),
    .i_addr  (r_addr),
    .i_wdata (addressDataIn),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_beat    <= '0;
      r_wait    <= '0;
      r_be      <= '0;
      r_wr_done <= 1'b0;
      r_dv      <= 1'b0;
      r_end     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_dv   <= 1'b0;
      r_end  <= 1'b0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (beginTransactionIn && w_hit) begin
            r_addr    <= w_idx;
            r_beat    <= burstSizeIn;
            r_be      <= byteEnablesIn;
            r_wait    <= WAIT_W'(WAIT_CYCLES);
            r_wr_done <= 1'b0;
            if (w_overrun) begin
              r_state <= S_ERR;
              r_end   <= 1'b1;
              r_err   <= 1'b1;
            end else if (readNotWriteIn) begin
              r_state <= S_RD_WAIT;
            end else begin
              r_state <= S_WR;
            end
          end
        end
        S_RD_WAIT: begin
          if (endTransactionIn) begin
            r_state <= S_IDLE;
          end else if (r_wait == '0) begin
            r_dv    <= 1'b1;
            r_addr  <= r_addr + ADDR_BITS'(1);
            r_state <= S_RD_BURST;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        // r_beat counts beats still to issue after the one currently on the bus.
        S_RD_BURST: begin
          if (endTransactionIn) begin
            r_state <= S_IDLE;
          end else if (r_beat == '0) begin
            r_end   <= 1'b1;
            r_state <= S_RD_END;
          end else begin
            r_dv   <= 1'b1;
            r_addr <= r_addr + ADDR_BITS'(1);
            r_beat <= r_beat - BEAT_W'(1);
          end
        end
        S_RD_END: r_state <= S_IDLE;
        S_WR: begin
          if (w_wr_accept) begin
            r_addr <= r_addr + ADDR_BITS'(1);
            if (r_beat == '0) begin
              r_wr_done <= 1'b1;
              r_busy    <= 1'b1;
            end else begin
              r_beat <= r_beat - BEAT_W'(1);
            end
          end
          if (endTransactionIn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addressDataOut    = w_rdata & {BUS_W{r_dv}};
  assign dataValidOut      = r_dv;
  assign endTransactionOut = r_end;
  assign busyOut           = r_busy;
  assign busErrorOut       = r_err;
  assign debugStateOut     = r_state;

endmodule

// File: tb/tb_bus_burst_target_ram.sv
// Directed bench for bus_burst_target_ram: writes, reads, byte lanes, decode errors,
// aborts, reset mid-burst and a WAIT_CYCLES=3 instance sharing the same bus inputs.
module tb_bus_burst_target_ram;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        begin_in = 1'b0;
  logic [31:0] ad_in = '0;
  logic        rnw_in = 1'b0;
  logic [7:0]  burst_in = '0;
  logic [3:0]  be_in = '0;
  logic        dv_in = 1'b0;
  logic        end_in = 1'b0;

  logic [31:0] ad_out, ad_out_w3;
  logic        dv_out, dv_out_w3;
  logic        end_out, end_out_w3;
  logic        busy_out, busy_out_w3;
  logic        err_out, err_out_w3;
  logic [2:0]  state_out, state_out_w3;

  int vectors = 0;
  int miscompares = 0;

  bus_burst_target_ram #(.BASE_ADDR(32'h5000_0000), .ADDR_BITS(9), .WAIT_CYCLES(0)) dut (
    .clock(clock), .reset(reset), .beginTransactionIn(begin_in), .addressDataIn(ad_in),
    .readNotWriteIn(rnw_in), .burstSizeIn(burst_in), .byteEnablesIn(be_in),
    .dataValidIn(dv_in), .endTransactionIn(end_in), .addressDataOut(ad_out),
    .dataValidOut(dv_out), .endTransactionOut(end_out), .busyOut(busy_out),
    .busErrorOut(err_out), .debugStateOut(state_out)
  );

  bus_burst_target_ram #(.BASE_ADDR(32'h5000_0000), .ADDR_BITS(9), .WAIT_CYCLES(3)) dut_w3 (
    .clock(clock), .reset(reset), .beginTransactionIn(begin_in), .addressDataIn(ad_in),
    .readNotWriteIn(rnw_in), .burstSizeIn(burst_in), .byteEnablesIn(be_in),
    .dataValidIn(dv_in), .endTransactionIn(end_in), .addressDataOut(ad_out_w3),
    .dataValidOut(dv_out_w3), .endTransactionOut(end_out_w3), .busyOut(busy_out_w3),
    .busErrorOut(err_out_w3), .debugStateOut(state_out_w3)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a begin cycle, then clears begin after the sampling edge.
  task automatic start(input logic [31:0] addr, input logic rnw, input logic [7:0] burst,
                       input logic [3:0] be);
    begin_in = 1'b1; ad_in = addr; rnw_in = rnw; burst_in = burst; be_in = be;
    tick();
    begin_in = 1'b0; ad_in = '0;
  endtask

  task automatic write_single(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be);
    start(addr, 1'b0, 8'd0, be);
    dv_in = 1'b1; ad_in = data;
    tick();
    dv_in = 1'b0; ad_in = '0; end_in = 1'b1;
    tick();
    end_in = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_dv", 32'(dv_out), 32'd0);
    chk("rst_data", ad_out, 32'd0);
    chk("rst_end", 32'(end_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    reset = 1'b1;
    tick();

    // Write 4 beats @0x5000_0010, data 1..4
    start(32'h5000_0010, 1'b0, 8'd3, 4'hF);
    chk("wr_state", 32'(state_out), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      dv_in = 1'b1; ad_in = 32'(i);
      tick();
      if (i == 1) chk("wr_busy_mid", 32'(busy_out), 32'd0);
    end
    chk("wr_busy_last", 32'(busy_out), 32'd1);
    dv_in = 1'b0; ad_in = '0; end_in = 1'b1;
    tick();
    end_in = 1'b0;
    chk("wr_end_busy", 32'(busy_out), 32'd0);
    chk("wr_end_state", 32'(state_out), 32'd0);

    // Read them back: beats at T+2..T+5, end at T+6
    start(32'h5000_0010, 1'b1, 8'd3, 4'h0);
    chk("rd_t1_dv", 32'(dv_out), 32'd0);
    chk("rd_t1_state", 32'(state_out), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rd_beat_dv", 32'(dv_out), 32'd1);
      chk("rd_beat_data", ad_out, 32'(i));
    end
    tick();
    chk("rd_end_dv", 32'(dv_out), 32'd0);
    chk("rd_end_data", ad_out, 32'd0);
    chk("rd_end_eot", 32'(end_out), 32'd1);
    chk("rd_end_state", 32'(state_out), 32'd3);
    tick();
    chk("rd_after_eot", 32'(end_out), 32'd0);
    chk("rd_after_state", 32'(state_out), 32'd0);

    // Byte enables
    write_single(32'h5000_0040, 32'h1111_1111, 4'hF);
    write_single(32'h5000_0040, 32'hAABB_CCDD, 4'b0101);
    start(32'h5000_0040, 1'b1, 8'd0, 4'h0);
    tick();
    chk("be_dv", 32'(dv_out), 32'd1);
    chk("be_data", ad_out, 32'h11BB_11DD);
    tick();
    chk("be_eot", 32'(end_out), 32'd1);
    tick();

    // Window overrun: error pulse at T+1 only
    start(32'h5000_07F8, 1'b1, 8'd3, 4'h0);
    chk("err_pulse", 32'(err_out), 32'd1);
    chk("err_eot", 32'(end_out), 32'd1);
    chk("err_dv", 32'(dv_out), 32'd0);
    chk("err_state", 32'(state_out), 32'd5);
    tick();
    chk("err_clear", 32'(err_out), 32'd0);
    chk("err_eot_clear", 32'(end_out), 32'd0);
    chk("err_idle", 32'(state_out), 32'd0);

    // Miss: silent
    start(32'h6000_0000, 1'b1, 8'd3, 4'h0);
    for (int i = 0; i < 8; i++) begin
      chk("miss_quiet", {ad_out[31:4], ad_out[3:0] | {dv_out, end_out, busy_out, err_out}},
          32'd0);
      tick();
    end

    // Write beyond burst: burstSize=1, four valid beats offered
    write_single(32'h5000_0108, 32'hCAFE_F00D, 4'hF);
    start(32'h5000_0100, 1'b0, 8'd1, 4'hF);
    dv_in = 1'b1; ad_in = 32'hA1A1_A1A1;
    tick();
    chk("wb_busy1", 32'(busy_out), 32'd0);
    ad_in = 32'hA2A2_A2A2;
    tick();
    chk("wb_busy2", 32'(busy_out), 32'd1);
    ad_in = 32'hA3A3_A3A3;
    tick();
    chk("wb_busy3", 32'(busy_out), 32'd0);
    ad_in = 32'hA4A4_A4A4;
    tick();
    chk("wb_busy4", 32'(busy_out), 32'd0);
    dv_in = 1'b0; ad_in = '0; end_in = 1'b1;
    tick();
    end_in = 1'b0;
    start(32'h5000_0100, 1'b1, 8'd2, 4'h0);
    tick();
    chk("wb_rd0", ad_out, 32'hA1A1_A1A1);
    tick();
    chk("wb_rd1", ad_out, 32'hA2A2_A2A2);
    tick();
    chk("wb_rd2", ad_out, 32'hCAFE_F00D);
    tick();
    chk("wb_eot", 32'(end_out), 32'd1);
    tick();

    // Read abort at beat 2 of 8
    start(32'h5000_0010, 1'b1, 8'd7, 4'h0);
    tick();
    chk("ab_b0", ad_out, 32'd1);
    tick();
    chk("ab_b1", ad_out, 32'd2);
    tick();
    chk("ab_b2", ad_out, 32'd3);
    end_in = 1'b1;
    tick();
    end_in = 1'b0;
    chk("ab_state", 32'(state_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("ab_quiet", {30'd0, dv_out, end_out}, 32'd0);
      tick();
    end

    // Reset in the middle of a 16-beat read
    start(32'h5000_0010, 1'b1, 8'd15, 4'h0);
    tick();
    tick();
    chk("mr_beat1", ad_out, 32'd2);
    chk("mr_state", 32'(state_out), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("mr_dv", 32'(dv_out), 32'd0);
    chk("mr_data", ad_out, 32'd0);
    chk("mr_eot", 32'(end_out), 32'd0);
    chk("mr_state_rst", 32'(state_out), 32'd0);
    #2 reset = 1'b1;
    tick();
    start(32'h5000_0014, 1'b1, 8'd0, 4'h0);
    tick();
    chk("mr_next_dv", 32'(dv_out), 32'd1);
    chk("mr_next_data", ad_out, 32'd2);
    tick();
    chk("mr_next_eot", 32'(end_out), 32'd1);
    for (int i = 0; i < 8; i++) tick();

    // WAIT_CYCLES=3 instance: first beat at T+5
    start(32'h5000_0010, 1'b1, 8'd1, 4'h0);
    tick(); tick(); tick();
    chk("w3_t4_dv", 32'(dv_out_w3), 32'd0);
    tick();
    chk("w3_t5_dv", 32'(dv_out_w3), 32'd1);
    chk("w3_t5_data", ad_out_w3, 32'd1);
    tick();
    chk("w3_t6_data", ad_out_w3, 32'd2);
    tick();
    chk("w3_t7_eot", 32'(end_out_w3), 32'd1);
    chk("w3_t7_dv", 32'(dv_out_w3), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
